// File: rtl/div_pkg.sv
// Shared definitions for the two-port divider arbiter: FSM state
// encoding, requester count and the divide-by-zero / overflow constants.
package div_pkg;

    localparam int NREQ = 2;

    // Widest operand the bypass constants below can serve.
    localparam int MAXW = 128;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } state_t;

    // Quotient returned for a zero divisor.
    localparam logic [MAXW-1:0] QUOT_DIV0 = '1;

    // Signed-minimum pattern for a w-bit operand: 1 followed by w-1 zeros.
    function automatic logic [MAXW-1:0] smin_pat(input int w);
        logic [MAXW-1:0] v;
        v = '0;
        v[w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The port granted last loses the next tie.
// Ports: i_req (requests), i_en (grant is consumed this cycle),
//        o_gnt (one-hot grant), o_gnt_id (granted port index).
module rr_arb2
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_gnt_id
);

    // Port that wins when both request.
    logic r_prio;
    logic w_id;

    always_comb begin
        w_id = 1'b0;
        if (i_req == 2'b11) begin
            w_id = r_prio;
        end else begin
            w_id = i_req[1];
        end
    end

    assign o_gnt    = (|i_req) ? (w_id ? 2'b10 : 2'b01) : 2'b00;
    assign o_gnt_id = w_id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_en && |i_req) begin
            r_prio <= ~w_id;
        end
    end

endmodule

// File: rtl/div_arb.sv
// Arbiter sharing one external divider between two requesters, with
// divide-by-zero and signed-overflow bypass and per-port flush.
// Ports: req_* (request side, two ports), flush (per-port kill),
//        resp_* (shared response, one-hot valid), div_* (divider side).
module div_arb
    import div_pkg::*;
#(
    parameter int W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ-1:0] req_sign,
    input  logic [W-1:0]    req_x0,
    input  logic [W-1:0]    req_y0,
    input  logic [W-1:0]    req_x1,
    input  logic [W-1:0]    req_y1,
    input  logic [NREQ-1:0] flush,
    output logic [NREQ-1:0] resp_valid,
    input  logic [NREQ-1:0] resp_ready,
    output logic [W-1:0]    resp_quot,
    output logic [W-1:0]    resp_rem,
    output logic            div_valid,
    output logic            div_sign,
    output logic [W-1:0]    div_x,
    output logic [W-1:0]    div_y,
    input  logic [W-1:0]    div_result,
    input  logic [W-1:0]    div_rem,
    input  logic            div_finish
);

    localparam logic [W-1:0] ALL1 = QUOT_DIV0[W-1:0];
    localparam logic [W-1:0] SMIN = W'(smin_pat(W));

    state_t r_state;
    state_t w_next;

    logic         r_owner;
    logic         r_sign;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_quot;
    logic [W-1:0] r_rem;
    logic         r_discard;

    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic            w_gid;
    logic            w_idle;
    logic            w_accept;
    logic            w_sel_sign;
    logic [W-1:0]    w_sel_x;
    logic [W-1:0]    w_sel_y;
    logic            w_div0;
    logic            w_ovf;
    logic            w_own_flush;
    logic            w_own_ready;
    logic            w_drop;
    logic [NREQ-1:0] w_own_oh;

    // A port under flush is never considered for a grant.
    assign w_req    = req_valid & ~flush;
    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && (|w_req);

    rr_arb2 u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (w_req),
        .i_en     (w_idle),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gid)
    );

    assign w_sel_sign = req_sign[w_gid];
    assign w_sel_x    = w_gid ? req_x1 : req_x0;
    assign w_sel_y    = w_gid ? req_y1 : req_y0;

    assign w_div0 = (w_sel_y == '0);
    assign w_ovf  = w_sel_sign && (w_sel_x == SMIN) && (w_sel_y == ALL1);

    assign w_own_flush = flush[r_owner];
    assign w_own_ready = resp_ready[r_owner];
    assign w_own_oh    = r_owner ? 2'b10 : 2'b01;

    // Result is thrown away if the owner was flushed at any point
    // after the divider was committed to.
    assign w_drop = r_discard || w_own_flush;

    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        div_valid  = 1'b0;
        resp_valid = '0;
        unique case (r_state)
            S_IDLE: begin
                req_ready = w_gnt;
                if (w_accept) begin
                    w_next = (w_div0 || w_ovf) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                div_valid = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (div_finish) begin
                    w_next = w_drop ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = w_own_oh;
                if (w_own_flush || w_own_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Outputs read as idle for the whole reset cycle.
        if (!rst_n) begin
            req_ready  = '0;
            div_valid  = 1'b0;
            resp_valid = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_owner   <= 1'b0;
            r_sign    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_discard <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner   <= w_gid;
                r_sign    <= w_sel_sign;
                r_x       <= w_sel_x;
                r_y       <= w_sel_y;
                r_discard <= 1'b0;
                if (w_div0) begin
                    r_quot <= ALL1;
                    r_rem  <= w_sel_x;
                end else if (w_ovf) begin
                    r_quot <= w_sel_x;
                    r_rem  <= '0;
                end
            end
            if ((r_state == S_ISSUE || r_state == S_WAIT) && w_own_flush) begin
                r_discard <= 1'b1;
            end
            if (r_state == S_WAIT && div_finish) begin
                r_discard <= 1'b0;
                if (!w_drop) begin
                    r_quot <= div_result;
                    r_rem  <= div_rem;
                end
            end
        end
    end

    assign resp_quot = r_quot;
    assign resp_rem  = r_rem;
    assign div_sign  = r_sign;
    assign div_x     = r_x;
    assign div_y     = r_y;

endmodule

// File: tb/tb_div_arb.sv
// Self-checking bench for div_arb with a behavioural divider model
// and a spec-level reference for quotient, remainder and latency.
module tb_div_arb;

    localparam int W = 64;
    localparam logic [W-1:0] SMIN = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid, req_ready, req_sign, flush;
    logic [W-1:0] req_x0, req_y0, req_x1, req_y1;
    logic [1:0]   resp_valid, resp_ready;
    logic [W-1:0] resp_quot, resp_rem;
    logic         div_valid, div_sign, div_finish;
    logic [W-1:0] div_x, div_y, div_result, div_rem;

    int n_cmp = 0;
    int n_bad = 0;
    int oh_bad = 0;

    div_arb #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sign   (req_sign),
        .req_x0     (req_x0),
        .req_y0     (req_y0),
        .req_x1     (req_x1),
        .req_y1     (req_y1),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_quot  (resp_quot),
        .resp_rem   (resp_rem),
        .div_valid  (div_valid),
        .div_sign   (div_sign),
        .div_x      (div_x),
        .div_y      (div_y),
        .div_result (div_result),
        .div_rem    (div_rem),
        .div_finish (div_finish)
    );

    always #5 clk = ~clk;

    // Reference division: zero divisor and signed overflow rules,
    // otherwise truncating division.
    function automatic void ref_div(input bit s, input logic [W-1:0] x,
                                    input logic [W-1:0] y,
                                    output logic [W-1:0] q,
                                    output logic [W-1:0] r,
                                    output bit byp);
        byp = 1'b1;
        if (y == '0) begin
            q = ONES;
            r = x;
        end else if (s && x == SMIN && y == ONES) begin
            q = x;
            r = '0;
        end else begin
            byp = 1'b0;
            if (s) begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end else begin
                q = x / y;
                r = x % y;
            end
        end
    endfunction

    // Divider model: dv_lat cycles from the start pulse to div_finish.
    int           dv_lat = 1;
    int           dv_cnt = 0;
    int           dv_pulses = 0;
    int           dv_fin = 0;
    bit           dv_busy = 1'b0;
    bit           dv_s;
    logic [W-1:0] dv_x, dv_y;

    initial begin
        logic [W-1:0] q, r;
        bit b;
        div_finish = 1'b0;
        div_result = '0;
        div_rem    = '0;
        forever begin
            @(negedge clk);
            div_finish = 1'b0;
            div_result = {$urandom, $urandom};
            div_rem    = {$urandom, $urandom};
            if (rst_n !== 1'b1) begin
                dv_busy = 1'b0;
            end else begin
                if (dv_busy) begin
                    dv_cnt--;
                    if (dv_cnt == 0) begin
                        dv_busy = 1'b0;
                        ref_div(dv_s, dv_x, dv_y, q, r, b);
                        div_result = q;
                        div_rem    = r;
                        div_finish = 1'b1;
                        dv_fin++;
                    end
                end
                if (div_valid === 1'b1) begin
                    dv_pulses++;
                    dv_busy = 1'b1;
                    dv_cnt  = dv_lat;
                    dv_s    = div_sign;
                    dv_x    = div_x;
                    dv_y    = div_y;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid === 2'b11) oh_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic issue(input int p, input bit s, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int lat);
        int k;
        dv_lat = lat;
        req_sign[p] = s;
        if (p == 0) begin
            req_x0 = x;
            req_y0 = y;
        end else begin
            req_x1 = x;
            req_y1 = y;
        end
        req_valid[p] = 1'b1;
        #1;
        k = 0;
        while (req_ready[p] !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("req_ready", W'(req_ready[p]), 64'd1);
    endtask

    task automatic wait_resp(input int p, input bit nf,
                             output logic [W-1:0] q, output logic [W-1:0] r,
                             output int lat, output logic [1:0] rv);
        step();
        req_valid = 2'b00;
        flush[1-p] = nf;
        lat = 1;
        while (resp_valid === 2'b00 && lat < 40) begin
            step();
            lat++;
        end
        flush = 2'b00;
        rv = resp_valid;
        q  = resp_quot;
        r  = resp_rem;
    endtask

    task automatic ack(input int p);
        resp_ready[p] = 1'b1;
        step();
        resp_ready = 2'b00;
    endtask

    task automatic run_op(input string nm, input int p, input bit s,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input int lat, input bit nf,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input bit byp);
        logic [W-1:0] q, r;
        logic [1:0]   rv;
        int           l, base;
        base = dv_pulses;
        issue(p, s, x, y, lat);
        wait_resp(p, nf, q, r, l, rv);
        chk({nm, "_rv"}, W'(rv), (p == 0) ? 64'd1 : 64'd2);
        chk({nm, "_quot"}, q, eq);
        chk({nm, "_rem"}, r, er);
        chk({nm, "_lat"}, W'(l), byp ? 64'd1 : W'(lat + 2));
        chk({nm, "_divv"}, W'(dv_pulses - base), byp ? 64'd0 : 64'd1);
        ack(p);
    endtask

    typedef struct {
        int           p;
        bit           s;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           lat;
        bit           byp;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [W-1:0] q, r, q0, r0, eq, er, x, y;
        logic [1:0]   rv;
        int           l, cnt, base, fbase, g, prio, v, p;
        bit           s, byp;

        tbl[0] = '{0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 3, 1'b0};
        tbl[1] = '{1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, ONES,
                   64'hFFFF_FFFF_FFFF_FFF9, 2, 1'b1};
        tbl[2] = '{0, 1'b1, SMIN, ONES, SMIN, 64'd0, 2, 1'b1};
        tbl[3] = '{1, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                   64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 5, 1'b0};
        tbl[4] = '{0, 1'b1, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
                   64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 2, 1'b0};
        tbl[5] = '{1, 1'b0, 64'd5, 64'd10, 64'd0, 64'd5, 1, 1'b0};
        tbl[6] = '{0, 1'b0, 64'd0, 64'd0, ONES, 64'd0, 1, 1'b1};
        tbl[7] = '{1, 1'b0, SMIN, ONES, 64'd0, SMIN, 2, 1'b0};
        tbl[8] = '{0, 1'b0, ONES, 64'd1, ONES, 64'd0, 4, 1'b0};

        rst_n = 1'b0;
        req_valid = 2'b11;
        req_sign = 2'b11;
        req_x0 = '0; req_y0 = '0; req_x1 = '0; req_y1 = '0;
        flush = 2'b00;
        resp_ready = 2'b00;

        repeat (3) step();
        chk("rst_req_ready", W'(req_ready), 64'd0);
        chk("rst_resp_valid", W'(resp_valid), 64'd0);
        chk("rst_div_valid", W'(div_valid), 64'd0);
        chk("rst_div_sign", W'(div_sign), 64'd0);
        chk("rst_div_x", div_x, 64'd0);
        chk("rst_resp_quot", resp_quot, 64'd0);
        req_valid = 2'b00;
        req_sign = 2'b00;
        rst_n = 1'b1;
        step();

        // Simultaneous requests alternate starting from port 0.
        prio = 0;
        for (int i = 0; i < 3; i++) begin
            g = prio;
            prio = 1 - g;
            dv_lat = 2;
            req_sign = 2'b00;
            req_x0 = 64'(1000 + i); req_y0 = 64'd3;
            req_x1 = 64'(2000 + i); req_y1 = 64'd7;
            req_valid = 2'b11;
            #1;
            cnt = 0;
            while (req_ready === 2'b00 && cnt < 20) begin
                step();
                cnt++;
            end
            chk("rr_grant", W'(req_ready), (g == 0) ? 64'd1 : 64'd2);
            wait_resp(g, 1'b0, q, r, l, rv);
            chk("rr_resp_port", W'(rv), (g == 0) ? 64'd1 : 64'd2);
            chk("rr_quot", q, (g == 0) ? 64'((1000 + i) / 3) : 64'((2000 + i) / 7));
            ack(g);
        end

        foreach (tbl[i]) begin
            run_op($sformatf("vec%0d", i), tbl[i].p, tbl[i].s, tbl[i].x,
                   tbl[i].y, tbl[i].lat, 1'b0, tbl[i].q, tbl[i].r, tbl[i].byp);
        end

        // Response held for 5 cycles must stay stable.
        issue(1, 1'b0, 64'd77, 64'd4, 2);
        wait_resp(1, 1'b0, q0, r0, l, rv);
        chk("stall_quot", q0, 64'd19);
        chk("stall_rem", r0, 64'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (resp_valid !== 2'b10 || resp_quot !== q0 || resp_rem !== r0)
                cnt++;
        end
        chk("stall_stable", W'(cnt), 64'd0);
        ack(1);

        // Owner flushed in WAIT: finish absorbed, nothing returned.
        base = dv_pulses;
        fbase = dv_fin;
        issue(0, 1'b0, 64'd50, 64'd5, 6);
        step();
        req_valid = 2'b00;
        step();
        flush[0] = 1'b1;
        step();
        flush = 2'b00;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (resp_valid !== 2'b00) cnt++;
        end
        chk("flw_no_resp", W'(cnt), 64'd0);
        chk("flw_finish", W'(dv_fin - fbase), 64'd1);
        chk("flw_divv", W'(dv_pulses - base), 64'd1);
        run_op("flw_next", 0, 1'b0, 64'd50, 64'd5, 2, 1'b0, 64'd10, 64'd0, 1'b0);

        // Owner flushed in RESP: valid drops on the next cycle.
        issue(0, 1'b0, 64'd9, 64'd2, 1);
        wait_resp(0, 1'b0, q, r, l, rv);
        chk("flr_rv", W'(rv), 64'd1);
        flush[0] = 1'b1;
        step();
        flush = 2'b00;
        chk("flr_drop", W'(resp_valid), 64'd0);

        // Flushed port is never granted.
        req_sign[1] = 1'b0;
        req_x1 = 64'd81; req_y1 = 64'd9;
        req_valid = 2'b10;
        flush = 2'b10;
        #1;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (req_ready !== 2'b00) cnt++;
            step();
        end
        chk("nof_blocked", W'(cnt), 64'd0);
        flush = 2'b00;
        run_op("nof_after", 1, 1'b0, 64'd81, 64'd9, 1, 1'b0, 64'd9, 64'd0, 1'b0);

        // Random operations, non-owner flush sometimes held meanwhile.
        for (int i = 0; i < 40; i++) begin
            p = int'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                v = int'($urandom_range(0, 2000)) - 1000;
                x = {{32{v[31]}}, v};
            end else begin
                x = {$urandom, $urandom};
            end
            case ($urandom_range(0, 5))
                0: y = '0;
                1: begin s = 1'b1; x = SMIN; y = ONES; end
                2: y = 64'($urandom_range(1, 20));
                3: y = ONES;
                default: y = {$urandom, $urandom};
            endcase
            ref_div(s, x, y, eq, er, byp);
            run_op($sformatf("rnd%0d", i), p, s, x, y,
                   int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
                   eq, er, byp);
        end

        // Reset while waiting on the divider.
        issue(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFCE, 64'd3, 8);
        step();
        req_valid = 2'b00;
        step();
        step();
        rst_n = 1'b0;
        req_valid = 2'b11;
        step();
        chk("rw_req_ready", W'(req_ready), 64'd0);
        chk("rw_resp_valid", W'(resp_valid), 64'd0);
        chk("rw_div_valid", W'(div_valid), 64'd0);
        chk("rw_div_sign", W'(div_sign), 64'd0);
        chk("rw_div_x", div_x, 64'd0);
        chk("rw_div_y", div_y, 64'd0);
        chk("rw_resp_quot", resp_quot, 64'd0);
        chk("rw_resp_rem", resp_rem, 64'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (resp_valid !== 2'b00) cnt++;
        end
        chk("rw_no_stale", W'(cnt), 64'd0);
        dv_lat = 3;
        req_sign = 2'b11;
        req_x0 = 64'hFFFF_FFFF_FFFF_FFCE; req_y0 = 64'd3;
        req_x1 = 64'd1; req_y1 = 64'd1;
        req_valid = 2'b11;
        #1;
        chk("rw_prio", W'(req_ready), 64'd1);
        wait_resp(0, 1'b0, q, r, l, rv);
        chk("rw_rv", W'(rv), 64'd1);
        chk("rw_quot", q, 64'hFFFF_FFFF_FFFF_FFF0);
        chk("rw_rem", r, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("rw_lat", W'(l), 64'd5);
        ack(0);

        chk("resp_onehot", W'(oh_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
